universal_shift_reg: RTL and testbench

Parametrised N-bit universal shift register with a word counter. It supersedes the fixed right-shift serial-in/parallel-out register. Each cycle it can hold, shift right, shift left or parallel-load, and it raises a one-cycle `word_done` pulse after N consecutive same-direction shifts. It sits between serial links (SPI/UART-style bit streams) and word-wide datapaths, serving as deserialiser, serialiser or loadable delay line.

---
 rtl/shift_pkg.sv | 16 +
 rtl/usr_bit_cell.sv | 43 ++++
 rtl/universal_shift_reg.sv | 100 ++++++++++
 tb/tb_universal_shift_reg.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared mode and direction encodings for the universal shift register.
package shift_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } shift_mode_t;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } shift_dir_t;

endpackage

// File: rtl/usr_bit_cell.sv
// One register bit: 4:1 next-value mux (hold / right-neighbour / left-neighbour / load)
// feeding a flop with synchronous reset to its own reset bit.
module usr_bit_cell
  import shift_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_en,
  input  logic [1:0] i_mode,
  input  logic       i_from_left,
  input  logic       i_from_right,
  input  logic       i_d,
  output logic       o_q
);

  logic r_q;
  logic w_next;

  always_comb begin
    w_next = r_q;
    if (i_en) begin
      case (shift_mode_t'(i_mode))
        MODE_SHR:  w_next = i_from_left;
        MODE_SHL:  w_next = i_from_right;
        MODE_LOAD: w_next = i_d;
        default:   w_next = r_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= RESET_BIT;
    end else begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/universal_shift_reg.sv
// N-bit universal shift register (hold / shift right / shift left / load) with a
// same-direction shift counter that pulses word_done after every N-th shift.
module universal_shift_reg
  import shift_pkg::*;
#(
  parameter int unsigned    N         = 4,
  parameter logic [N-1:0]   RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  si_r,
  input  logic                  si_l,
  input  logic [N-1:0]          d,
  output logic [N-1:0]          q,
  output logic                  so_r,
  output logic                  so_l,
  output logic [$clog2(N)-1:0]  cnt,
  output logic                  word_done
);

  localparam int unsigned    CW   = $clog2(N);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  logic [N-1:0]  w_from_left;
  logic [N-1:0]  w_from_right;

  logic [CW-1:0] r_cnt;
  shift_dir_t    r_dir;
  logic          r_done;

  logic [CW-1:0] w_cnt_next;
  shift_dir_t    w_dir_next;
  logic          w_done_next;
  shift_mode_t   w_mode;
  shift_dir_t    w_shift_dir;
  logic          w_is_shift;

  // Edge cells take the serial inputs; interior cells take their neighbours.
  assign w_from_left  = {si_r, q[N-1:1]};
  assign w_from_right = {q[N-2:0], si_l};

  for (genvar k = 0; k < N; k++) begin : g_cell
    usr_bit_cell #(
      .RESET_BIT (RESET_VAL[k])
    ) u_cell (
      .clk          (clk),
      .reset        (reset),
      .i_en         (en),
      .i_mode       (mode),
      .i_from_left  (w_from_left[k]),
      .i_from_right (w_from_right[k]),
      .i_d          (d[k]),
      .o_q          (q[k])
    );
  end

  // Word counter: a direction change restarts the count at 1; load clears it
  // without touching the stored direction.
  always_comb begin
    w_mode      = shift_mode_t'(mode);
    w_is_shift  = en && ((w_mode == MODE_SHR) || (w_mode == MODE_SHL));
    w_shift_dir = (w_mode == MODE_SHL) ? DIR_LEFT : DIR_RIGHT;
    w_cnt_next  = r_cnt;
    w_dir_next  = r_dir;
    w_done_next = 1'b0;
    if (en && (w_mode == MODE_LOAD)) begin
      w_cnt_next = '0;
    end else if (w_is_shift) begin
      w_dir_next = w_shift_dir;
      if (w_shift_dir != r_dir) begin
        w_cnt_next = CW'(1);
      end else if (r_cnt == LAST) begin
        w_cnt_next  = '0;
        w_done_next = 1'b1;
      end else begin
        w_cnt_next = r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_dir  <= DIR_RIGHT;
      r_done <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_dir  <= w_dir_next;
      r_done <= w_done_next;
    end
  end

  assign so_r      = q[0];
  assign so_l      = q[N-1];
  assign cnt       = r_cnt;
  assign word_done = r_done;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (N=4) with an expected-value scoreboard.
module tb_universal_shift_reg;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         si_r = 1'b0;
  logic         si_l = 1'b0;
  logic [N-1:0] d = '0;

  logic [N-1:0] q, q9;
  logic         so_r, so_l, so_r9, so_l9;
  logic [1:0]   cnt, cnt9;
  logic         word_done, word_done9;

  typedef struct packed {
    logic [3:0] q;
    logic [1:0] cnt;
    logic       wd;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    checks = 0;
  int    passed = 0;
  int    failed = 0;

  always #5 clk = ~clk;

  universal_shift_reg #(.N(N), .RESET_VAL(4'h0)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .si_r(si_r), .si_l(si_l),
    .d(d), .q(q), .so_r(so_r), .so_l(so_l), .cnt(cnt), .word_done(word_done)
  );

  universal_shift_reg #(.N(N), .RESET_VAL(4'h9)) dut9 (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .si_r(si_r), .si_l(si_l),
    .d(d), .q(q9), .so_r(so_r9), .so_l(so_l9), .cnt(cnt9), .word_done(word_done9)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected result, then compare after the edge.
  task automatic step(input logic rst, input logic e, input logic [1:0] m,
                      input logic sr, input logic sl, input logic [3:0] dd,
                      input logic [3:0] eq, input logic [1:0] ec, input logic ew,
                      input string tag);
    exp_t x;
    string t;
    @(negedge clk);
    reset = rst; en = e; mode = m; si_r = sr; si_l = sl; d = dd;
    sb.push_back('{q: eq, cnt: ec, wd: ew});
    tags.push_back(tag);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    t = tags.pop_front();
    chk({t, ".q"},    32'(q),         32'(x.q));
    chk({t, ".cnt"},  32'(cnt),       32'(x.cnt));
    chk({t, ".wd"},   32'(word_done), 32'(x.wd));
    chk({t, ".so_r"}, 32'(so_r),      32'(x.q[0]));
    chk({t, ".so_l"}, 32'(so_l),      32'(x.q[3]));
  endtask

  task automatic rand_reset_step(input string tag);
    step(1'b1, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
         4'b0000, 2'd0, 1'b0, tag);
    chk({tag, ".q9"}, 32'(q9), 32'h9);
    chk({tag, ".cnt9"}, 32'(cnt9), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for two cycles with random inputs
    rand_reset_step("rst0");
    rand_reset_step("rst1");

    // Right deserialise 1,0,1,1
    step(0, 1, 2'b01, 1, 0, 4'h0, 4'b1000, 2'd1, 0, "shr1");
    step(0, 1, 2'b01, 0, 0, 4'h0, 4'b0100, 2'd2, 0, "shr2");
    step(0, 1, 2'b01, 1, 0, 4'h0, 4'b1010, 2'd3, 0, "shr3");
    step(0, 1, 2'b01, 1, 0, 4'h0, 4'b1101, 2'd0, 1, "shr4");
    step(0, 1, 2'b00, 0, 0, 4'h0, 4'b1101, 2'd0, 0, "hold_after_word");

    // Left deserialise 1,1,0,0 from 0000, then en=0 freeze
    step(0, 1, 2'b11, 0, 0, 4'h0, 4'b0000, 2'd0, 0, "clr_load");
    step(0, 1, 2'b10, 0, 1, 4'h0, 4'b0001, 2'd1, 0, "shl1");
    step(0, 1, 2'b10, 0, 1, 4'h0, 4'b0011, 2'd2, 0, "shl2");
    step(0, 1, 2'b10, 0, 0, 4'h0, 4'b0110, 2'd3, 0, "shl3");
    step(0, 1, 2'b10, 0, 0, 4'h0, 4'b1100, 2'd0, 1, "shl4");
    step(0, 0, 2'b01, 1, 1, 4'hF, 4'b1100, 2'd0, 0, "en0_a");
    step(0, 0, 2'b10, 1, 1, 4'hF, 4'b1100, 2'd0, 0, "en0_b");
    step(0, 0, 2'b11, 1, 1, 4'hF, 4'b1100, 2'd0, 0, "en0_c");

    // Load then serialise out through so_r
    step(0, 1, 2'b11, 0, 0, 4'b1010, 4'b1010, 2'd0, 0, "load1010");
    chk("ser0.so_r_pre", 32'(so_r), 32'h0);
    step(0, 1, 2'b01, 0, 0, 4'h0, 4'b0101, 2'd1, 0, "ser1");
    chk("ser1.so_r_pre", 32'(so_r), 32'h1);
    step(0, 1, 2'b01, 0, 0, 4'h0, 4'b0010, 2'd2, 0, "ser2");
    chk("ser2.so_r_pre", 32'(so_r), 32'h0);
    step(0, 1, 2'b01, 0, 0, 4'h0, 4'b0001, 2'd3, 0, "ser3");
    chk("ser3.so_r_pre", 32'(so_r), 32'h1);
    step(0, 1, 2'b01, 0, 0, 4'h0, 4'b0000, 2'd0, 1, "ser4");

    // Direction change restarts the count
    step(0, 1, 2'b01, 1, 0, 4'h0, 4'b1000, 2'd1, 0, "dir_r1");
    step(0, 1, 2'b01, 1, 0, 4'h0, 4'b1100, 2'd2, 0, "dir_r2");
    step(0, 1, 2'b10, 0, 0, 4'h0, 4'b1000, 2'd1, 0, "dir_l1");
    step(0, 1, 2'b10, 0, 1, 4'h0, 4'b0001, 2'd2, 0, "dir_l2");
    step(0, 1, 2'b10, 0, 1, 4'h0, 4'b0011, 2'd3, 0, "dir_l3");
    step(0, 1, 2'b10, 0, 1, 4'h0, 4'b0111, 2'd0, 1, "dir_l4");

    // Load wins over a completing count; next same-direction shift counts 1
    step(0, 1, 2'b10, 0, 0, 4'h0, 4'b1110, 2'd1, 0, "pre_ld1");
    step(0, 1, 2'b10, 0, 0, 4'h0, 4'b1100, 2'd2, 0, "pre_ld2");
    step(0, 1, 2'b10, 0, 0, 4'h0, 4'b1000, 2'd3, 0, "pre_ld3");
    step(0, 1, 2'b11, 0, 0, 4'b0101, 4'b0101, 2'd0, 0, "load_prio");
    step(0, 1, 2'b00, 0, 0, 4'h0, 4'b0101, 2'd0, 0, "load_nopulse");
    step(0, 1, 2'b10, 0, 0, 4'h0, 4'b1010, 2'd1, 0, "post_load_shl");

    // Reset mid-word suppresses the pending word_done
    step(0, 1, 2'b11, 0, 0, 4'h0, 4'b0000, 2'd0, 0, "mw_clr");
    step(0, 1, 2'b01, 1, 0, 4'h0, 4'b1000, 2'd1, 0, "mw_r1");
    step(0, 1, 2'b01, 1, 0, 4'h0, 4'b1100, 2'd2, 0, "mw_r2");
    step(0, 1, 2'b01, 1, 0, 4'h0, 4'b1110, 2'd3, 0, "mw_r3");
    step(1, 1, 2'b01, 1, 0, 4'h0, 4'b0000, 2'd0, 0, "mw_rst");
    chk("mw_rst.q9", 32'(q9), 32'h9);
    step(0, 1, 2'b00, 0, 0, 4'h0, 4'b0000, 2'd0, 0, "mw_after");
    step(0, 1, 2'b01, 1, 0, 4'h0, 4'b1000, 2'd1, 0, "mw_restart");

    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
